// File: rtl/i2c_slave.sv
// I2C slave: one address byte plus a single data byte per transfer, either written or read.
// scl and sda are synchronised to clk; this block only ever pulls sda low or releases it.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0]  ADDR        = 7'h2A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  logic       sda,
    input  logic       scl,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       nack_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_DATA   = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_RD_DATA   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [2:0]             r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_rw;
    logic [7:0]             r_tx;
    logic                   r_sda_oe;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_busy;
    logic                   r_nack_err;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign nack_err = r_nack_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync[0] <= scl;
            r_sda_sync[0] <= sda;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_scl_sync[i] <= r_scl_sync[i-1];
                r_sda_sync[i] <= r_sda_sync[i-1];
            end
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // In the ACK states r_sda_oe doubles as the phase flag: the first scl fall starts driving, the second ends the ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd7;
            r_shift    <= '0;
            r_rw       <= 1'b0;
            r_tx       <= '0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_nack_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state    <= ST_ADDR;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
                r_bit_cnt  <= 3'd7;
                r_nack_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: if (w_scl_rise) begin
                        r_shift <= {r_shift[5:0], w_sda};
                        if (r_bit_cnt == 3'd0) begin
                            r_rw      <= w_sda;
                            r_bit_cnt <= 3'd7;
                            if (r_shift == ADDR) begin
                                r_state <= ST_ADDR_ACK;
                                r_busy  <= 1'b1;
                                r_tx    <= tx_data;
                            end else begin
                                r_state <= ST_WAIT_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end
                    ST_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            r_sda_oe <= 1'b1;
                        end else if (r_rw) begin
                            r_state  <= ST_RD_DATA;
                            r_sda_oe <= ~r_tx[7];
                        end else begin
                            r_state  <= ST_WR_DATA;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    ST_WR_DATA: if (w_scl_rise) begin
                        r_shift <= {r_shift[5:0], w_sda};
                        if (r_bit_cnt == 3'd0) begin
                            r_rx_data  <= {r_shift, w_sda};
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= 3'd7;
                            r_state    <= ST_WR_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end
                    ST_WR_ACK: if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_WAIT_STOP;
                        end
                    end
                    ST_RD_DATA: if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd7;
                            r_state   <= ST_RD_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_sda_oe  <= ~r_tx[r_bit_cnt - 3'd1];
                        end
                    end
                    ST_RD_ACK: if (w_scl_rise) begin
                        if (w_sda) r_nack_err <= 1'b1;
                        r_state <= ST_WAIT_STOP;
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a timed bus master drives transfers; received bytes are checked against a queue of expected values.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 50;
    localparam int H = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       nack_err;

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt = 0;
    int slave_low = 0;
    int busy_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sda      (sda_bus),
        .scl      (scl),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .nack_err (nack_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_bus === 1'b0 && !m_sda_low) slave_low++;
        if (busy) busy_cnt++;
        if (rst && rx_valid) begin
            rx_cnt++;
            check("rx_q_nonempty", 32'(exp_rx_q.size() != 0), 32'(1));
            if (exp_rx_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
        end
    end

    // Works both from idle (scl high) and as a repeated START (scl low).
    task automatic i2c_start();
        m_sda_low = 1'b0;
        #Q;
        scl = 1'b1;
        #H;
        m_sda_low = 1'b1;
        #H;
        scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        #Q;
        scl = 1'b1;
        #H;
        m_sda_low = 1'b0;
        #H;
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        #Q;
        scl = 1'b1;
        #H;
        scl = 1'b0;
        #Q;
    endtask

    task automatic sample_bit(input logic drive_low, output logic b);
        m_sda_low = drive_low;
        #Q;
        scl = 1'b1;
        #(H/2);
        b = sda_bus;
        #(H/2);
        scl = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sample_bit(1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        logic unused_ack;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sample_bit(1'b0, b);
            d = {d[6:0], b};
        end
        sample_bit(~nack, unused_ack);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rxb;
        int         lowb;
        int         busyb;

        #12;
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_nack_err", 32'(nack_err), 0);
        check("rst_sda", 32'(sda_bus), 32'(1));
        rst = 1'b1;
        #H;

        // Write 0xA5 to 0x2A
        rxb = rx_cnt;
        exp_rx_q.push_back(8'hA5);
        i2c_start();
        write_byte(8'h54, ack);
        check("wr_addr_ack", 32'(ack), 0);
        check("wr_busy", 32'(busy), 32'(1));
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 0);
        i2c_stop();
        check("wr_busy_stop", 32'(busy), 0);
        check("wr_rx_data", 32'(rx_data), 32'(8'hA5));
        check("wr_rx_pulses", 32'(rx_cnt - rxb), 32'(1));
        check("wr_q_drained", 32'(exp_rx_q.size()), 0);

        // Read 0x3C with master NACK
        rxb = rx_cnt;
        tx_data = 8'h3C;
        exp_rd_q.push_back(8'h3C);
        i2c_start();
        write_byte(8'h55, ack);
        check("rd_addr_ack", 32'(ack), 0);
        read_byte(1'b1, d);
        check("rd_byte", 32'(d), 32'(exp_rd_q.pop_front()));
        i2c_stop();
        check("rd_nack_err", 32'(nack_err), 32'(1));
        check("rd_busy_stop", 32'(busy), 0);
        check("rd_no_rx", 32'(rx_cnt - rxb), 0);

        // Address mismatch
        rxb = rx_cnt;
        lowb = slave_low;
        busyb = busy_cnt;
        i2c_start();
        check("mm_nack_clr", 32'(nack_err), 0);
        write_byte(8'h56, ack);
        check("mm_addr_nack", 32'(ack), 32'(1));
        write_byte(8'hFF, ack);
        check("mm_data_nack", 32'(ack), 32'(1));
        i2c_stop();
        check("mm_sda_never_low", 32'(slave_low - lowb), 0);
        check("mm_busy_never", 32'(busy_cnt - busyb), 0);
        check("mm_no_rx", 32'(rx_cnt - rxb), 0);
        check("mm_rx_data_kept", 32'(rx_data), 32'(8'hA5));

        // Repeated START after 4 write bits, then a read; tx_data changes after address ACK
        rxb = rx_cnt;
        tx_data = 8'h96;
        exp_rd_q.push_back(8'h96);
        i2c_start();
        write_byte(8'h54, ack);
        check("rs_wr_addr_ack", 32'(ack), 0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_start();
        check("rs_busy_clr", 32'(busy), 0);
        write_byte(8'h55, ack);
        check("rs_rd_addr_ack", 32'(ack), 0);
        check("rs_busy", 32'(busy), 32'(1));
        tx_data = 8'h00;
        read_byte(1'b0, d);
        check("rs_rd_byte", 32'(d), 32'(exp_rd_q.pop_front()));
        i2c_stop();
        check("rs_nack_err", 32'(nack_err), 0);
        check("rs_no_rx", 32'(rx_cnt - rxb), 0);

        // Reset while the slave drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b0 : ((8'h54 >> i) & 1) != 0);
        m_sda_low = 1'b0;
        #Q;
        check("ra_ack_driven", 32'(sda_bus), 0);
        rst = 1'b0;
        #1;
        check("ra_sda_released", 32'(sda_bus), 32'(1));
        check("ra_busy", 32'(busy), 0);
        check("ra_rx_data", 32'(rx_data), 0);
        check("ra_rx_valid", 32'(rx_valid), 0);
        check("ra_nack_err", 32'(nack_err), 0);
        #1;
        rst = 1'b1;
        #Q;
        i2c_stop();
        rxb = rx_cnt;
        exp_rx_q.push_back(8'h0F);
        i2c_start();
        write_byte(8'h54, ack);
        check("ra_wr_addr_ack", 32'(ack), 0);
        write_byte(8'h0F, ack);
        check("ra_wr_data_ack", 32'(ack), 0);
        i2c_stop();
        check("ra_rx_data_after", 32'(rx_data), 32'(8'h0F));
        check("ra_rx_pulses", 32'(rx_cnt - rxb), 32'(1));

        // STOP in the middle of a data byte
        rxb = rx_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        check("sm_addr_ack", 32'(ack), 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        check("sm_busy", 32'(busy), 0);
        check("sm_sda", 32'(sda_bus), 32'(1));
        check("sm_no_rx", 32'(rx_cnt - rxb), 0);
        check("sm_rx_data_kept", 32'(rx_data), 32'(8'h0F));

        #H;
        check("end_rx_q_drained", 32'(exp_rx_q.size()), 0);
        check("end_rd_q_drained", 32'(exp_rd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
